// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline interlock control/status bundle
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    // IF/ID view
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_uses_rt;
    logic             ID_Branch;
    logic             ID_Jump;
    logic             branch_taken;
    logic             ID_md_use;
    // Downstream producers
    logic             ID_EX_MemRead;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_Rt;
    logic [4:0]       ID_EX_Rd;
    logic             EX_MEM_MemRead;
    logic [4:0]       EX_MEM_Rd;
    logic             md_start;
    // Pipeline control and status
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Flush;
    logic             IF_ID_Flush;
    logic             md_busy;
    logic             md_error;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ID_Rs, ID_Rt, ID_uses_rt, ID_Branch, ID_Jump, branch_taken,
               ID_md_use, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rt, ID_EX_Rd,
               EX_MEM_MemRead, EX_MEM_Rd, md_start,
        input  PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
               md_busy, md_error, stall_cycles
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_uses_rt, ID_Branch, ID_Jump, branch_taken,
               ID_md_use, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rt, ID_EX_Rd,
               EX_MEM_MemRead, EX_MEM_Rd, md_start,
        output PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
               md_busy, md_error, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch/mult-div interlock with stall counter
module hazard_stall_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_unit_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    localparam logic [5:0]       LP_CNT_INIT = 6'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] LP_SAT      = '1;

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [5:0]       r_cnt;
    logic [5:0]       w_cnt_nxt;
    logic             r_md_error;
    logic             w_md_error_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_match_id_ex_rt;
    logic w_match_id_ex_rd;
    logic w_match_ex_mem_rd;
    logic w_load_use;
    logic w_br_alu;
    logic w_br_mem;
    logic w_md_haz;
    logic w_stall;
    logic w_md_busy;

    // $zero is hardwired, so a write to it can never be a true dependency.
    assign w_match_id_ex_rt  = (bus.ID_EX_Rt != 5'd0) &&
                               ((bus.ID_EX_Rt == bus.ID_Rs) ||
                                (bus.ID_uses_rt && (bus.ID_EX_Rt == bus.ID_Rt)));
    assign w_match_id_ex_rd  = (bus.ID_EX_Rd != 5'd0) &&
                               ((bus.ID_EX_Rd == bus.ID_Rs) ||
                                (bus.ID_uses_rt && (bus.ID_EX_Rd == bus.ID_Rt)));
    assign w_match_ex_mem_rd = (bus.EX_MEM_Rd != 5'd0) &&
                               ((bus.EX_MEM_Rd == bus.ID_Rs) ||
                                (bus.ID_uses_rt && (bus.EX_MEM_Rd == bus.ID_Rt)));

    assign w_md_busy  = (r_state == S_BUSY);
    assign w_load_use = bus.ID_EX_MemRead && w_match_id_ex_rt;
    assign w_br_alu   = bus.ID_Branch && bus.ID_EX_RegWrite && !bus.ID_EX_MemRead &&
                        w_match_id_ex_rd;
    assign w_br_mem   = bus.ID_Branch && bus.EX_MEM_MemRead && w_match_ex_mem_rd;
    assign w_md_haz   = bus.ID_md_use && w_md_busy;
    assign w_stall    = w_load_use | w_br_alu | w_br_mem | w_md_haz;

    // A stalled branch is re-evaluated next cycle, so its decision is dropped here.
    assign bus.PCWrite      = !w_stall;
    assign bus.IF_ID_Write  = !w_stall;
    assign bus.ID_EX_Flush  = w_stall;
    assign bus.IF_ID_Flush  = !w_stall && ((bus.ID_Branch && bus.branch_taken) || bus.ID_Jump);
    assign bus.md_busy      = w_md_busy;
    assign bus.md_error     = r_md_error;
    assign bus.stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_md_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_md_error <= w_md_error_nxt;
        end
    end

    // A second start while busy is not restarted; the first operation keeps counting.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_md_error_nxt = r_md_error;
        case (r_state)
            S_IDLE: begin
                if (bus.md_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = LP_CNT_INIT;
                end
            end
            S_BUSY: begin
                if (bus.md_start) begin
                    w_md_error_nxt = 1'b1;
                end
                if (r_cnt != 6'd0) begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != LP_SAT)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed vectors for hazard_stall_unit
module tb_hazard_stall_unit;
    localparam int MD_LAT = 4;
    localparam int CW     = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    hazard_stall_unit_if #(.CNT_W(CW)) bus ();

    hazard_stall_unit #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ID_Rs          = 5'd0;
        bus.ID_Rt          = 5'd0;
        bus.ID_uses_rt     = 1'b0;
        bus.ID_Branch      = 1'b0;
        bus.ID_Jump        = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.ID_md_use      = 1'b0;
        bus.ID_EX_MemRead  = 1'b0;
        bus.ID_EX_RegWrite = 1'b0;
        bus.ID_EX_Rt       = 5'd0;
        bus.ID_EX_Rd       = 5'd0;
        bus.EX_MEM_MemRead = 1'b0;
        bus.EX_MEM_Rd      = 5'd0;
        bus.md_start       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic stall, input logic ifid_flush);
        chk({tag, ".PCWrite"},     32'(bus.PCWrite),     32'(!stall));
        chk({tag, ".IF_ID_Write"}, 32'(bus.IF_ID_Write), 32'(!stall));
        chk({tag, ".ID_EX_Flush"}, 32'(bus.ID_EX_Flush), 32'(stall));
        chk({tag, ".IF_ID_Flush"}, 32'(bus.IF_ID_Flush), 32'(ifid_flush));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst.md_busy",  32'(bus.md_busy),  32'd0);
        chk("rst.md_error", 32'(bus.md_error), 32'd0);
        chk("rst.cnt",      32'(bus.stall_cycles), 32'd0);
        chk_ctrl("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();

        // load-use on Rs
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd8; bus.ID_Rs = 5'd8;
        #1; chk_ctrl("lu", 1'b1, 1'b0);
        cyc();
        clear_inputs();
        #1; chk_ctrl("lu.after", 1'b0, 1'b0);
        chk("lu.cnt", 32'(bus.stall_cycles), 32'd1);
        // $zero never matches
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd0; bus.ID_Rs = 5'd0;
        #1; chk_ctrl("lu.r0", 1'b0, 1'b0);
        // Rt ignored when ID does not read it
        bus.ID_EX_Rt = 5'd8; bus.ID_Rs = 5'd3; bus.ID_Rt = 5'd8; bus.ID_uses_rt = 1'b0;
        #1; chk_ctrl("lu.nort", 1'b0, 1'b0);
        bus.ID_uses_rt = 1'b1;
        #1; chk_ctrl("lu.rt", 1'b1, 1'b0);

        // lw then beq: two stall cycles, then taken branch flushes
        pulse_reset();
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd9;
        bus.ID_Branch = 1'b1; bus.ID_Rt = 5'd9; bus.ID_Rs = 5'd4;
        bus.ID_uses_rt = 1'b1; bus.branch_taken = 1'b1;
        #1; chk_ctrl("lwbr.c1", 1'b1, 1'b0);
        cyc();
        bus.ID_EX_MemRead = 1'b0; bus.ID_EX_Rt = 5'd0;
        bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Rd = 5'd9;
        #1; chk_ctrl("lwbr.c2", 1'b1, 1'b0);
        cyc();
        bus.EX_MEM_MemRead = 1'b0; bus.EX_MEM_Rd = 5'd0;
        #1; chk_ctrl("lwbr.c3", 1'b0, 1'b1);
        chk("lwbr.cnt", 32'(bus.stall_cycles), 32'd2);

        // ALU result feeding a branch
        pulse_reset();
        bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_Rd = 5'd10;
        bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd10; bus.branch_taken = 1'b1;
        #1; chk_ctrl("bralu.c1", 1'b1, 1'b0);
        cyc();
        bus.ID_EX_RegWrite = 1'b0; bus.ID_EX_Rd = 5'd0;
        bus.EX_MEM_Rd = 5'd10;
        #1; chk_ctrl("bralu.c2", 1'b0, 1'b1);
        bus.branch_taken = 1'b0;
        #1; chk_ctrl("br.nt", 1'b0, 1'b0);
        // non-branch ignores EX/MEM load
        bus.ID_Branch = 1'b0; bus.EX_MEM_MemRead = 1'b1; bus.EX_MEM_Rd = 5'd10;
        #1; chk_ctrl("brmem.nobr", 1'b0, 1'b0);
        clear_inputs();
        bus.ID_Jump = 1'b1;
        #1; chk_ctrl("jump", 1'b0, 1'b1);

        // mult/div busy window with mfhi held in ID
        pulse_reset();
        bus.md_start = 1'b1; bus.ID_md_use = 1'b1;
        #1; chk("md.T.busy", 32'(bus.md_busy), 32'd0);
        chk_ctrl("md.T", 1'b0, 1'b0);
        cyc();
        bus.md_start = 1'b0;
        for (int k = 1; k <= MD_LAT; k++) begin
            #1;
            chk($sformatf("md.T%0d.busy", k), 32'(bus.md_busy), 32'd1);
            chk($sformatf("md.T%0d.PCWrite", k), 32'(bus.PCWrite), 32'd0);
            cyc();
        end
        #1; chk("md.end.busy", 32'(bus.md_busy), 32'd0);
        chk_ctrl("md.end", 1'b0, 1'b0);
        chk("md.cnt", 32'(bus.stall_cycles), 32'd4);

        // restart while busy sets sticky error, window unchanged
        pulse_reset();
        bus.ID_md_use = 1'b1;
        bus.md_start = 1'b1;                       // T
        cyc(); bus.md_start = 1'b0;                // T+1
        cyc(); bus.md_start = 1'b1;                // T+2
        #1; chk("err.T2", 32'(bus.md_error), 32'd0);
        cyc(); bus.md_start = 1'b0;                // T+3
        #1; chk("err.T3", 32'(bus.md_error), 32'd1);
        chk("err.T3.busy", 32'(bus.md_busy), 32'd1);
        cyc();                                      // T+4
        #1; chk("err.T4.busy", 32'(bus.md_busy), 32'd1);
        cyc(); bus.md_start = 1'b1;                // T+5
        #1; chk("err.T5.busy", 32'(bus.md_busy), 32'd0);
        chk("err.T5", 32'(bus.md_error), 32'd1);
        cyc(); bus.md_start = 1'b0;                // T+6, busy again
        #1; chk("err.T6.busy", 32'(bus.md_busy), 32'd1);
        chk("err.T6.cnt", 32'(bus.stall_cycles), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("arst.busy",  32'(bus.md_busy),  32'd0);
        chk("arst.error", 32'(bus.md_error), 32'd0);
        chk("arst.cnt",   32'(bus.stall_cycles), 32'd0);
        chk_ctrl("arst", 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_inputs();

        // saturation of the stall counter
        cyc();
        bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd5; bus.ID_Rs = 5'd5;
        for (int k = 0; k < 14; k++) cyc();
        #1; chk("sat.14", 32'(bus.stall_cycles), 32'd14);
        for (int k = 0; k < (1 << CW) + 5 - 14; k++) cyc();
        #1; chk("sat.hold", 32'(bus.stall_cycles), 32'd15);
        chk_ctrl("sat", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
